// File: rtl/irrigation_actuator_seq.sv
// Actuator sequencer: opens the selected valve before starting the shared pump,
// and stops the pump before closing the valve. Both valves are never open together.
module irrigation_actuator_seq #(
  parameter int OPEN_CYC = 4,
  parameter int STOP_CYC = 4,
  parameter int CW       = 8
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic [1:0] cmd,
  output logic       valve_asp,
  output logic       valve_got,
  output logic       pump,
  output logic       busy,
  output logic [1:0] active,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    OPENING  = 2'd1,
    RUNNING  = 2'd2,
    STOPPING = 2'd3
  } state_t;

  localparam logic [CW-1:0] OPEN_LOAD = CW'(OPEN_CYC - 1);
  localparam logic [CW-1:0] STOP_LOAD = CW'(STOP_CYC - 1);

  state_t        state, state_n;
  logic [1:0]    mode, mode_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          asp_n, got_n, pump_n, busy_n;
  logic [1:0]    active_n;
  logic          cmd_valid;

  // cmd is a level from a CLK-synchronous FSM; 11 is treated like 00.
  assign cmd_valid = (cmd == 2'b01) || (cmd == 2'b10);
  assign dbg_state = state;

  always_comb begin
    state_n  = state;
    mode_n   = mode;
    cnt_n    = cnt;
    asp_n    = valve_asp;
    got_n    = valve_got;
    pump_n   = pump;
    active_n = active;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          mode_n  = cmd;
          asp_n   = (cmd == 2'b01);
          got_n   = (cmd == 2'b10);
          cnt_n   = OPEN_LOAD;
          state_n = OPENING;
        end
      end
      OPENING: begin
        if (cmd != mode) begin
          // Abort before the pump ever starts.
          asp_n   = 1'b0;
          got_n   = 1'b0;
          mode_n  = 2'b00;
          cnt_n   = '0;
          state_n = IDLE;
        end else if (cnt == '0) begin
          pump_n   = 1'b1;
          active_n = mode;
          state_n  = RUNNING;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      RUNNING: begin
        if (cmd != mode) begin
          pump_n   = 1'b0;
          active_n = 2'b00;
          cnt_n    = STOP_LOAD;
          state_n  = STOPPING;
        end
      end
      STOPPING: begin
        // Drain is not abortable; cmd is ignored here.
        if (cnt == '0) begin
          asp_n   = 1'b0;
          got_n   = 1'b0;
          mode_n  = 2'b00;
          state_n = IDLE;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: begin
        asp_n    = 1'b0;
        got_n    = 1'b0;
        pump_n   = 1'b0;
        active_n = 2'b00;
        mode_n   = 2'b00;
        cnt_n    = '0;
        state_n  = IDLE;
      end
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      mode      <= 2'b00;
      cnt       <= '0;
      valve_asp <= 1'b0;
      valve_got <= 1'b0;
      pump      <= 1'b0;
      busy      <= 1'b0;
      active    <= 2'b00;
    end else begin
      state     <= state_n;
      mode      <= mode_n;
      cnt       <= cnt_n;
      valve_asp <= asp_n;
      valve_got <= got_n;
      pump      <= pump_n;
      busy      <= busy_n;
      active    <= active_n;
    end
  end

endmodule

// File: tb/tb_irrigation_actuator_seq.sv
// Directed bench for irrigation_actuator_seq: table of cmd steps with expected
// outputs, plus short-timing instance and asynchronous reset corner cases.
module tb_irrigation_actuator_seq;

  logic       CLK;
  logic       reset;
  logic [1:0] cmd, cmd1;
  logic       valve_asp, valve_got, pump, busy;
  logic [1:0] active, dbg_state;
  logic       valve_asp1, valve_got1, pump1, busy1;
  logic [1:0] active1, dbg_state1;

  irrigation_actuator_seq #(.OPEN_CYC(4), .STOP_CYC(4), .CW(8)) u_dut (
    .CLK(CLK), .reset(reset), .cmd(cmd),
    .valve_asp(valve_asp), .valve_got(valve_got), .pump(pump), .busy(busy),
    .active(active), .dbg_state(dbg_state)
  );

  irrigation_actuator_seq #(.OPEN_CYC(1), .STOP_CYC(1), .CW(8)) u_dut1 (
    .CLK(CLK), .reset(reset), .cmd(cmd1),
    .valve_asp(valve_asp1), .valve_got(valve_got1), .pump(pump1), .busy(busy1),
    .active(active1), .dbg_state(dbg_state1)
  );

  // clock/reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // expected output word: {valve_asp, valve_got, pump, busy, active[1:0], state[1:0]}
  typedef struct {
    logic [1:0] cmd;
    logic [7:0] exp;
  } vec_t;

  localparam logic [1:0] S_I = 2'd0, S_O = 2'd1, S_R = 2'd2, S_S = 2'd3;

  vec_t       vq[$];
  logic [7:0] exp_q[$];
  int         nvec = 0;
  int         nmiss = 0;

  function automatic logic [7:0] pk(input logic a, input logic g, input logic p,
                                    input logic b, input logic [1:0] act,
                                    input logic [1:0] st);
    return {a, g, p, b, act, st};
  endfunction

  function automatic logic [7:0] obs0();
    return {valve_asp, valve_got, pump, busy, active, dbg_state};
  endfunction

  function automatic logic [7:0] obs1();
    return {valve_asp1, valve_got1, pump1, busy1, active1, dbg_state1};
  endfunction

  task automatic add(input logic [1:0] c, input logic [7:0] e, input int n = 1);
    vec_t v;
    v.cmd = c;
    v.exp = e;
    for (int i = 0; i < n; i++) vq.push_back(v);
  endtask

  // scoreboard compare against the head of the expected queue
  task automatic check(input string name, input logic [7:0] act);
    logic [7:0] e;
    e = exp_q.pop_front();
    nvec++;
    if (act !== e) begin
      nmiss++;
      $display("FAIL %s: got %b want %b (asp,got,pump,busy,active,state)", name, act, e);
    end
  endtask

  task automatic check_excl(input string name, input logic a, input logic g);
    nvec++;
    if ((a & g) !== 1'b0) begin
      nmiss++;
      $display("FAIL %s: both valves open asp=%b got=%b want not both 1", name, a, g);
    end
  endtask

  // driver: called at a negedge, applies cmd, samples at the following negedge
  task automatic step_main(input logic [1:0] c, input logic [7:0] e, input string name);
    cmd = c;
    exp_q.push_back(e);
    @(posedge CLK);
    @(negedge CLK);
    check(name, obs0());
    check_excl({name, "_excl"}, valve_asp, valve_got);
  endtask

  task automatic step_short(input logic [1:0] c, input logic [7:0] e, input string name);
    cmd1 = c;
    exp_q.push_back(e);
    @(posedge CLK);
    @(negedge CLK);
    check(name, obs1());
  endtask

  localparam logic [7:0] Z = 8'h00;

  initial begin
    logic [7:0] e_asp_open, e_asp_run, e_asp_stop;
    logic [7:0] e_got_open, e_got_run, e_got_stop;
    e_asp_open = pk(1, 0, 0, 1, 2'b00, S_O);
    e_asp_run  = pk(1, 0, 1, 1, 2'b01, S_R);
    e_asp_stop = pk(1, 0, 0, 1, 2'b00, S_S);
    e_got_open = pk(0, 1, 0, 1, 2'b00, S_O);
    e_got_run  = pk(0, 1, 1, 1, 2'b10, S_R);
    e_got_stop = pk(0, 1, 0, 1, 2'b00, S_S);

    // start with cmd=01 held from reset: valve now, pump 4 edges later
    add(2'b01, e_asp_open, 4);
    add(2'b01, e_asp_run, 2);
    // stop; cmd toggling during drain is ignored, drain still takes 4 edges
    add(2'b00, e_asp_stop);
    add(2'b01, e_asp_stop);
    add(2'b00, e_asp_stop);
    add(2'b01, e_asp_stop);
    add(2'b00, Z);
    // 11 and 00 in IDLE do nothing
    add(2'b11, Z);
    add(2'b00, Z);
    // abort: drip for 2 cycles then 00
    add(2'b10, e_got_open, 2);
    add(2'b00, Z);
    // drip full start, then switch straight to sprinkler
    add(2'b10, e_got_open, 4);
    add(2'b10, e_got_run);
    add(2'b01, e_got_stop, 4);
    add(2'b01, Z);
    add(2'b01, e_asp_open, 4);
    add(2'b01, e_asp_run);
    // 11 while running is a stop request
    add(2'b11, e_asp_stop, 4);
    add(2'b11, Z);
    // bring drip to RUNNING for the asynchronous reset check
    add(2'b10, e_got_open, 4);
    add(2'b10, e_got_run);

    // reset held with cmd=01 and clock running
    reset = 1'b0;
    cmd   = 2'b01;
    cmd1  = 2'b00;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK);
      @(negedge CLK);
      exp_q.push_back(Z);
      check($sformatf("reset_hold%0d", i), obs0());
    end
    reset = 1'b1;

    foreach (vq[i]) step_main(vq[i].cmd, vq[i].exp, $sformatf("vec%0d", i));

    // OPEN_CYC=STOP_CYC=1: pump one edge after valve, valve one edge after pump
    step_short(2'b01, pk(1, 0, 0, 1, 2'b00, S_O), "short_open");
    step_short(2'b01, pk(1, 0, 1, 1, 2'b01, S_R), "short_run");
    step_short(2'b00, pk(1, 0, 0, 1, 2'b00, S_S), "short_stop");
    step_short(2'b00, Z, "short_idle");

    // main instance is still running drip; pull reset between edges
    exp_q.push_back(e_got_run);
    check("pre_async", obs0());
    @(posedge CLK);
    #3;
    reset = 1'b0;
    #1;
    exp_q.push_back(Z);
    check("async_reset", obs0());
    @(negedge CLK);
    reset = 1'b1;
    cmd   = 2'b00;
    exp_q.push_back(Z);
    check("post_async", obs0());

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
    $finish;
  end

endmodule
